// File: rtl/tube_scan_ctrl.sv
// Seven-segment tube scan scheduler: rotates a shared segment bus across
// the digits, blanks each slot briefly, and snapshots digits once per frame.
module tube_scan_ctrl #(
    parameter int NUM_DIG   = 4,
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic [4*NUM_DIG-1:0]   din,
    input  logic [NUM_DIG-1:0]     dp,
    input  logic                   lz_en,
    output logic [NUM_DIG-1:0]     an,
    output logic [7:0]             seg,
    output logic                   frame_start
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(NUM_DIG);

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

    state_t               state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [IW-1:0]        idx, idx_n;
    logic                 snap;
    logic [4*NUM_DIG-1:0] d_snap;
    logic [NUM_DIG-1:0]   b_snap, dp_snap, blank_n;
    logic                 lead;
    logic [3:0]           cur_d;
    logic [NUM_DIG-1:0]   an_n;
    logic [7:0]           seg_n;

    function automatic logic [6:0] dec(input logic [3:0] d);
        case (d)
            4'd0:    dec = 7'b1000000;
            4'd1:    dec = 7'b1111001;
            4'd2:    dec = 7'b0100100;
            4'd3:    dec = 7'b0110000;
            4'd4:    dec = 7'b0011001;
            4'd5:    dec = 7'b0010010;
            4'd6:    dec = 7'b0000010;
            4'd7:    dec = 7'b1111000;
            4'd8:    dec = 7'b0000000;
            4'd9:    dec = 7'b0010000;
            default: dec = 7'b0111111;
        endcase
    endfunction

    // Zeros above the first non-zero digit go dark; digit 0 always shows.
    always_comb begin
        blank_n = '0;
        lead    = 1'b1;
        for (int i = NUM_DIG - 1; i > 0; i--) begin
            lead       = lead && (din[4*i +: 4] == 4'd0);
            blank_n[i] = lz_en && lead;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        snap    = 1'b0;
        if (!en) begin
            state_n = IDLE;
            cnt_n   = '0;
            idx_n   = '0;
        end else if (state == IDLE) begin
            cnt_n   = '0;
            idx_n   = '0;
            snap    = 1'b1;
            state_n = (BLANK_CYC > 0) ? BLANK : SHOW;
        end else begin
            if (cnt == CW'(SCAN_DIV - 1)) begin
                cnt_n = '0;
                if (idx == IW'(NUM_DIG - 1)) begin
                    idx_n = '0;
                    snap  = 1'b1;
                end else begin
                    idx_n = idx + 1'b1;
                end
            end else begin
                cnt_n = cnt + 1'b1;
            end
            state_n = (int'(cnt_n) < BLANK_CYC) ? BLANK : SHOW;
        end
    end

    assign cur_d = d_snap[int'(idx)*4 +: 4];

    always_comb begin
        an_n  = '1;
        seg_n = 8'hFF;
        if (state == SHOW) begin
            an_n  = ~(NUM_DIG'(1) << idx);
            seg_n = {~dp_snap[idx], b_snap[idx] ? 7'h7F : dec(cur_d)};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            d_snap      <= '0;
            b_snap      <= '0;
            dp_snap     <= '0;
            an          <= '1;
            seg         <= 8'hFF;
            frame_start <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            idx         <= idx_n;
            an          <= an_n;
            seg         <= seg_n;
            frame_start <= snap;
            if (snap) begin
                d_snap  <= din;
                b_snap  <= blank_n;
                dp_snap <= dp;
            end
        end
    end

endmodule

// File: tb/tb_tube_scan_ctrl.sv
// Bench for tube_scan_ctrl: directed plan plus random stimulus, checked
// against a frame-time model of the scan.
module tb_tube_scan_ctrl;

    localparam int ND = 4;
    localparam int SD = 8;
    localparam int BC = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic [4*ND-1:0] din;
    logic [ND-1:0] dp;
    logic          lz_en;
    logic [ND-1:0] an;
    logic [7:0]    seg;
    logic          frame_start;

    tube_scan_ctrl #(.NUM_DIG(ND), .SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
        .clk(clk), .reset(reset), .en(en), .din(din), .dp(dp),
        .lz_en(lz_en), .an(an), .seg(seg), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: pos = cycles since the enabling edge, -1 when idle.
    localparam logic [6:0] SEGS [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

    int         pos = -1;
    logic [3:0] md [ND];
    logic       mb [ND];
    logic       mdp [ND];
    logic [ND-1:0] e_an;
    logic [7:0] e_seg;
    logic       e_fs;

    task automatic take_snap();
        bit seen = 0;
        for (int i = ND - 1; i >= 0; i--) begin
            md[i]  = din[4*i +: 4];
            mdp[i] = dp[i];
            if (md[i] != 0 || i == 0) seen = 1;
            mb[i] = lz_en && !seen;
        end
    endtask

    task automatic model_step();
        int slot;
        if (!reset) begin
            e_an = '1; e_seg = 8'hFF; e_fs = 0; pos = -1;
            for (int i = 0; i < ND; i++) begin
                md[i] = 0; mb[i] = 0; mdp[i] = 0;
            end
            return;
        end
        if (pos < 0 || (pos % SD) < BC) begin
            e_an = '1; e_seg = 8'hFF;
        end else begin
            slot  = (pos / SD) % ND;
            e_an  = ~(ND'(1) << slot);
            e_seg = {~mdp[slot], mb[slot] ? 7'h7F : SEGS[md[slot]]};
        end
        if (!en) begin
            pos = -1; e_fs = 0;
        end else begin
            pos  = (pos < 0) ? 0 : pos + 1;
            e_fs = (pos % (ND * SD)) == 0;
            if (e_fs) take_snap();
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        chk("an", an, e_an);
        chk("seg", seg, e_seg);
        chk("fs", frame_start, e_fs);
    endtask

    task automatic wait_fs(output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (!frame_start && n < 100);
        if (!frame_start) chk("fs_wait", 0, 1);
    endtask

    int n;

    initial begin
        reset = 0; en = 1; din = '0; dp = '0; lz_en = 0;
        repeat (3) begin
            cyc();
            chk("rst_an", an, 4'hF);
            chk("rst_seg", seg, 8'hFF);
            chk("rst_fs", frame_start, 0);
        end

        reset = 1; din = 16'h5901;
        cyc();
        chk("fs_first", frame_start, 1);
        cyc(); cyc();
        chk("blank_an", an, 4'hF);
        cyc();
        chk("d0_an", an, 4'hE);
        chk("d0_seg", seg, 8'hF9);
        wait_fs(n);
        chk("period", n + 3, 32);

        repeat (10) cyc();
        din = 16'h1234;
        repeat (22) cyc();
        wait_fs(n);
        repeat (40) cyc();

        din = 16'h0007; lz_en = 1;
        wait_fs(n);
        repeat (32) cyc();
        lz_en = 0;
        wait_fs(n);
        repeat (32) cyc();

        din = 16'h00A0; dp = 4'b0100;
        wait_fs(n);
        repeat (32) cyc();

        wait_fs(n);
        repeat (21) cyc();
        en = 0;
        cyc(); cyc();
        chk("en_off_an", an, 4'hF);
        chk("en_off_seg", seg, 8'hFF);
        repeat (4) cyc();
        en = 1;
        cyc();
        chk("reen_fs", frame_start, 1);
        repeat (4) cyc();
        chk("reen_d0", an, 4'hE);

        wait_fs(n);
        repeat (21) cyc();
        reset = 0;
        cyc();
        chk("rst_mid_an", an, 4'hF);
        chk("rst_mid_seg", seg, 8'hFF);
        reset = 1;
        repeat (3) cyc();

        for (int k = 0; k < 3000; k++) begin
            din   = 16'($urandom);
            if ($urandom_range(0, 3) == 0) din[15:8] = 8'h00;
            dp    = 4'($urandom);
            lz_en = 1'($urandom);
            en    = ($urandom_range(0, 63) != 0);
            reset = ($urandom_range(0, 299) != 0);
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
